// File: rtl/ternary_full_adder_pkg.sv
// Shared trit encoding for the balanced-ternary adder: code type, named codes, decode helper.
package ternary_full_adder_pkg;

  localparam int unsigned TRIT_W = 2;
  localparam int unsigned SUM_W  = 3;

  typedef logic [TRIT_W-1:0] trit_t;

  localparam trit_t VNEG  = 2'b11;
  localparam trit_t VZERO = 2'b00;
  localparam trit_t VPOS  = 2'b01;
  localparam trit_t VINV  = 2'b10;

  // Invalid code decodes to zero; callers flag it separately.
  function automatic logic signed [TRIT_W-1:0] trit_to_int(input trit_t t);
    logic signed [TRIT_W-1:0] v;
    v = '0;
    case (t)
      VNEG:    v = -2'sd1;
      VPOS:    v = 2'sd1;
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/ternary_full_adder_trit_decode.sv
// Converts one encoded trit into a signed value and an invalid-code flag.
module trit_decode
  import ternary_full_adder_pkg::*;
(
  input  trit_t                    code,
  output logic signed [TRIT_W-1:0] val_c,
  output logic                     inv_c
);

  always_comb begin
    val_c = trit_to_int(code);
    inv_c = (code == VINV);
  end

endmodule

// File: rtl/ternary_full_adder.sv
// Balanced-ternary full adder: three encoded trits in, sum/carry trits out after one register stage.
module ternary_full_adder
  import ternary_full_adder_pkg::*;
#(
  parameter int unsigned ERR_EN = 1
) (
  input  logic  clk,
  input  logic  rst_n,
  input  logic  in_valid,
  input  trit_t a,
  input  trit_t b,
  input  trit_t cin,
  output logic  out_valid,
  output trit_t sum,
  output trit_t cout,
  output logic  err
);

  localparam bit ERR_ON = (ERR_EN != 0);

  logic signed [TRIT_W-1:0] va_c, vb_c, vc_c;
  logic                     inva_c, invb_c, invc_c;
  logic signed [SUM_W-1:0]  t_c;
  logic                     inv_any_c;
  trit_t                    sum_c, cout_c;

  trit_decode u_dec_a (.code(a),   .val_c(va_c), .inv_c(inva_c));
  trit_decode u_dec_b (.code(b),   .val_c(vb_c), .inv_c(invb_c));
  trit_decode u_dec_c (.code(cin), .val_c(vc_c), .inv_c(invc_c));

  // Sum in -3..+3 folded into a digit in -1..+1 and a carry such that t = sum + 3*cout.
  always_comb begin
    t_c       = {va_c[TRIT_W-1], va_c} + {vb_c[TRIT_W-1], vb_c} + {vc_c[TRIT_W-1], vc_c};
    inv_any_c = ERR_ON && (inva_c || invb_c || invc_c);
    sum_c     = VZERO;
    cout_c    = VZERO;
    case (t_c)
      3'b011:  begin sum_c = VZERO; cout_c = VPOS; end
      3'b010:  begin sum_c = VNEG;  cout_c = VPOS; end
      3'b001:  begin sum_c = VPOS;  cout_c = VZERO; end
      3'b111:  begin sum_c = VNEG;  cout_c = VZERO; end
      3'b110:  begin sum_c = VPOS;  cout_c = VNEG; end
      3'b101:  begin sum_c = VZERO; cout_c = VNEG; end
      default: begin sum_c = VZERO; cout_c = VZERO; end
    endcase
    if (inv_any_c) begin
      sum_c  = VZERO;
      cout_c = VZERO;
    end
  end

  // Single output stage; results hold while no new operand set is accepted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      sum       <= VZERO;
      cout      <= VZERO;
      err       <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        sum  <= sum_c;
        cout <= cout_c;
        err  <= inv_any_c;
      end
    end
  end

endmodule

// File: tb/tb_ternary_full_adder.sv
// Self-checking bench for ternary_full_adder against an integer balanced-ternary model.
module tb_ternary_full_adder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] a = 2'b00, b = 2'b00, cin = 2'b00;
  logic       out_valid, err;
  logic [1:0] sum, cout;

  int checks = 0;
  int passed = 0;

  logic [1:0] es = 2'b00, ec = 2'b00;
  logic       ee = 1'b0;

  ternary_full_adder #(.ERR_EN(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin),
    .out_valid(out_valid), .sum(sum), .cout(cout), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int dec(input logic [1:0] c);
    if (c == 2'b01) return 1;
    if (c == 2'b11) return -1;
    return 0;
  endfunction

  function automatic logic [1:0] enc(input int v);
    if (v == 1) return 2'b01;
    if (v == -1) return 2'b11;
    return 2'b00;
  endfunction

  task automatic model(input logic [1:0] x, input logic [1:0] y, input logic [1:0] z);
    int t, co;
    if (x == 2'b10 || y == 2'b10 || z == 2'b10) begin
      es = 2'b00; ec = 2'b00; ee = 1'b1;
    end else begin
      t  = dec(x) + dec(y) + dec(z);
      co = (t > 1) ? 1 : ((t < -1) ? -1 : 0);
      es = enc(t - 3 * co);
      ec = enc(co);
      ee = 1'b0;
    end
  endtask

  // Drive one cycle of inputs, then sample just after the capturing edge.
  task automatic step(input logic [1:0] x, input logic [1:0] y, input logic [1:0] z, input logic v);
    a = x; b = y; cin = z; in_valid = v;
    if (v && rst_n) model(x, y, z);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic test_reset;
    #2;
    checks++;
    if ({out_valid, sum, cout, err} !== 6'b0)
      $display("FAIL reset_async: got ov=%b sum=%b cout=%b err=%b, want all zero", out_valid, sum, cout, err);
    else passed++;
    a = 2'b01; b = 2'b01; cin = 2'b01; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({out_valid, sum, cout, err} !== 6'b0)
      $display("FAIL reset_ignores_inputs: got ov=%b sum=%b cout=%b err=%b, want all zero", out_valid, sum, cout, err);
    else passed++;
    in_valid = 1'b0;
    rst_n = 1'b1;
  endtask

  task automatic test_directed;
    logic [1:0] da [6] = '{2'b01, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00};
    logic [1:0] db [6] = '{2'b01, 2'b11, 2'b01, 2'b11, 2'b11, 2'b00};
    logic [1:0] dc [6] = '{2'b00, 2'b00, 2'b01, 2'b11, 2'b00, 2'b00};
    logic [1:0] ws [6] = '{2'b11, 2'b00, 2'b00, 2'b00, 2'b01, 2'b00};
    logic [1:0] wc [6] = '{2'b01, 2'b00, 2'b01, 2'b11, 2'b11, 2'b00};
    for (int i = 0; i < 6; i++) begin
      a = da[i]; b = db[i]; cin = dc[i]; in_valid = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if ({out_valid, sum, cout, err} !== {1'b1, ws[i], wc[i], 1'b0})
        $display("FAIL directed_%0d: got ov=%b sum=%b cout=%b err=%b, want ov=1 sum=%b cout=%b err=0",
                 i, out_valid, sum, cout, err, ws[i], wc[i]);
      else passed++;
    end
    in_valid = 1'b0;
    es = 2'b00; ec = 2'b00; ee = 1'b0;
  endtask

  task automatic test_hold;
    step(2'b01, 2'b01, 2'b00, 1'b1);
    step(2'b11, 2'b11, 2'b11, 1'b0);
    step(2'b00, 2'b01, 2'b01, 1'b0);
    checks++;
    if ({out_valid, sum, cout, err} !== {1'b0, 2'b11, 2'b01, 1'b0})
      $display("FAIL hold_idle: got ov=%b sum=%b cout=%b err=%b, want ov=0 sum=11 cout=01 err=0",
               out_valid, sum, cout, err);
    else passed++;
  endtask

  task automatic test_sweep;
    logic [1:0] codes [3] = '{2'b11, 2'b00, 2'b01};
    for (int i = 0; i < 27; i++) begin
      step(codes[i / 9], codes[(i / 3) % 3], codes[i % 3], 1'b1);
      checks++;
      if (out_valid !== 1'b1 || err !== 1'b0 || sum === 2'b10 || cout === 2'b10 ||
          dec(codes[i / 9]) + dec(codes[(i / 3) % 3]) + dec(codes[i % 3]) != dec(sum) + 3 * dec(cout))
        $display("FAIL sweep_%0d: a=%b b=%b cin=%b got ov=%b sum=%b cout=%b err=%b, want sum+3*cout=a+b+cin",
                 i, codes[i / 9], codes[(i / 3) % 3], codes[i % 3], out_valid, sum, cout, err);
      else passed++;
    end
  endtask

  task automatic test_invalid;
    step(2'b10, 2'b01, 2'b00, 1'b1);
    checks++;
    if ({out_valid, sum, cout, err} !== {1'b1, 2'b00, 2'b00, 1'b1})
      $display("FAIL invalid_set: got ov=%b sum=%b cout=%b err=%b, want ov=1 sum=00 cout=00 err=1",
               out_valid, sum, cout, err);
    else passed++;
    step(2'b01, 2'b00, 2'b00, 1'b1);
    checks++;
    if ({out_valid, sum, cout, err} !== {1'b1, 2'b01, 2'b00, 1'b0})
      $display("FAIL invalid_clear: got ov=%b sum=%b cout=%b err=%b, want ov=1 sum=01 cout=00 err=0",
               out_valid, sum, cout, err);
    else passed++;
  endtask

  task automatic test_back_to_back;
    logic v;
    for (int i = 0; i < 200; i++) begin
      v = ($urandom % 4) != 0;
      step(2'($urandom), 2'($urandom), 2'($urandom), v);
      checks++;
      if ({out_valid, sum, cout, err} !== {v, es, ec, ee})
        $display("FAIL random_%0d: got ov=%b sum=%b cout=%b err=%b, want ov=%b sum=%b cout=%b err=%b",
                 i, out_valid, sum, cout, err, v, es, ec, ee);
      else passed++;
    end
  endtask

  task automatic test_midreset;
    step(2'b01, 2'b01, 2'b00, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, sum, cout, err} !== 6'b0)
      $display("FAIL midreset_immediate: got ov=%b sum=%b cout=%b err=%b, want all zero", out_valid, sum, cout, err);
    else passed++;
    a = 2'b01; b = 2'b01; cin = 2'b01; in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    #2;
    rst_n = 1'b1;
    es = 2'b00; ec = 2'b00; ee = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if ({out_valid, sum, cout, err} !== 6'b0)
      $display("FAIL midreset_release: got ov=%b sum=%b cout=%b err=%b, want all zero", out_valid, sum, cout, err);
    else passed++;
    step(2'b11, 2'b11, 2'b00, 1'b1);
    checks++;
    if ({out_valid, sum, cout, err} !== {1'b1, es, ec, ee})
      $display("FAIL midreset_resume: got ov=%b sum=%b cout=%b err=%b, want ov=1 sum=%b cout=%b err=%b",
               out_valid, sum, cout, err, es, ec, ee);
    else passed++;
  endtask

  initial begin
    test_reset();
    @(posedge clk);
    #1;
    test_directed();
    test_hold();
    test_sweep();
    test_invalid();
    test_back_to_back();
    test_midreset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/ternary_full_adder.md
TERNARY_FULL_ADDER -- requirements
Module: ternary_full_adder

Interface
REQ-001 Parameter: ERR_EN, default 1, enables invalid-code detection (0: err tied low, invalid codes decoded as 0).
REQ-002 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-003 clk  input  1  rising-edge clock.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 in_valid  input  1  a/b/cin qualified this cycle.
REQ-006 a  input  2  trit operand A, encoded.
REQ-007 b  input  2  trit operand B, encoded.
REQ-008 cin  input  2  carry-in trit, encoded.
REQ-009 out_valid  output  1  sum/cout/err updated this cycle.
REQ-010 sum  output  2  sum trit, encoded.
REQ-011 cout  output  2  carry-out trit, encoded.
REQ-012 err  output  1  registered operand contained an invalid code.

Function
REQ-013 Trit encoding SHALL be 2-bit two's complement: 2'b11 = -1 (VNEG), 2'b00 = 0 (VZERO), 2'b01 = +1 (VPOS), 2'b10 = invalid.
REQ-014 Arithmetic SHALL be balanced ternary: t = a + b + cin, range -3..+3, computed in 3-bit signed.
REQ-015 Mapping t -> (sum, cout) SHALL be: +3->(0,+1), +2->(-1,+1), +1->(+1,0), 0->(0,0), -1->(-1,0), -2->(+1,-1), -3->(0,-1); invariant t = sum + 3*cout.
REQ-016 Latency SHALL be exactly one cycle: inputs sampled on the clk edge with in_valid=1 appear on sum/cout/err at that edge, with out_valid=1 for that one cycle.
REQ-017 With in_valid=0, out_valid SHALL be 0 next cycle and sum/cout/err SHALL hold their previous values.
REQ-018 Back-to-back in_valid SHALL be accepted every cycle; no backpressure, no stall.
REQ-019 With ERR_EN=1, any operand equal to 2'b10 while in_valid=1 SHALL register err=1, sum=0, cout=0, out_valid=1.
REQ-020 err SHALL clear on the next accepted valid operand set.
REQ-021 Outputs SHALL never carry code 2'b10.
REQ-022 With ERR_EN=0, an invalid code SHALL be treated as 0 and err SHALL stay 0.

Reset
REQ-023 rst_n low SHALL immediately force out_valid=0, sum=2'b00, cout=2'b00, err=0, independent of clk.
REQ-024 Inputs SHALL be ignored while rst_n is low.
REQ-025 Reset deassertion SHALL be synchronized by the integrator; the first accepted input is on the first rising edge with rst_n high.
REQ-026 Reset asserted mid-stream SHALL drop any in-flight result; no output from before the reset reappears.

Structure
REQ-027 A shared package SHALL hold the trit typedef (2-bit) and constants VNEG, VZERO, VPOS, VINV plus a function to decode a trit to a signed integer.
REQ-028 One sub-module, trit_decode, SHALL convert one encoded trit to a 2-bit signed value plus an invalid flag; it is instantiated three times.
REQ-029 The sum/cout mapping SHALL be combinational ahead of a single output register stage.

Verification
REQ-030 a=+1, b=+1, cin=0, in_valid=1 -> next cycle sum=-1 (2'b11), cout=+1 (2'b01), out_valid=1, err=0.
REQ-031 a=+1, b=-1, cin=0 -> sum=0, cout=0; then a=+1, b=+1, cin=+1 -> sum=0, cout=+1, on consecutive cycles.
REQ-032 a=-1, b=-1, cin=-1 -> sum=0, cout=-1; a=-1, b=-1, cin=0 -> sum=+1, cout=-1.
REQ-033 Exhaustive sweep of all 27 valid (a, b, cin) combinations -> t == sum + 3*cout for every case, out_valid=1 each cycle.
REQ-034 a=2'b10 with in_valid=1 -> err=1, sum=0, cout=0; the next valid input clears err.
REQ-035 rst_n pulled low between clock edges after a valid input -> outputs zero immediately; no out_valid pulse after release until new in_valid.
